// File: rtl/regfile_op_sequencer.sv
// Command sequencer for a 4x8 register file: fetch ra, fetch rb, execute ALU op, write back to rd.
// Optional build macro RF_SEQ_DUP_READ_SKIP_EN: when ra==rb the second read cycle is skipped.
module regfile_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_MOV} op_t;

`ifdef RF_SEQ_DUP_READ_SKIP_EN
  localparam bit DUP_SKIP = 1'b1;
`else
  localparam bit DUP_SKIP = 1'b0;
`endif

  state_t              r_state;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_rb;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_ready;
  logic [ADDR_W-1:0]   r_raddr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic                r_z;
  logic                r_n;
  logic                r_v;

  logic [DATA_W-1:0]   w_alu;
  logic                w_v;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_alu = r_b;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu = r_a + r_b;
        w_v   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_SUB: begin
        w_alu = r_a - r_b;
        w_v   = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_AND:  w_alu = r_a & r_b;
      OP_MOV:  w_alu = r_b;
      default: w_alu = r_b;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_rb     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ready  <= 1'b1;
      r_raddr  <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_op    <= op_t'(cmd_op);
            r_rd    <= cmd_rd;
            r_rb    <= cmd_rb;
            r_raddr <= cmd_ra;
            r_ready <= 1'b0;
            r_state <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_a <= rf_rdata;
          // r_raddr still holds ra here, so it doubles as the duplicate-operand compare
          if (DUP_SKIP && (r_raddr == r_rb)) begin
            r_b     <= rf_rdata;
            r_state <= S_EXEC;
          end else begin
            r_raddr <= r_rb;
            r_state <= S_RD_B;
          end
        end
        S_RD_B: begin
          r_b     <= rf_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_alu;
          r_z      <= (w_alu == '0);
          r_n      <= w_alu[DATA_W-1];
          r_v      <= w_v;
          r_we     <= 1'b1;
          r_done   <= 1'b1;
          r_waddr  <= r_rd;
          r_wdata  <= w_alu;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign rf_raddr  = r_raddr;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign done      = r_done;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer: directed commands push expected write-backs,
// a negedge monitor pops and compares whenever rf_we is seen.
module tb_regfile_op_sequencer;

  localparam int DW = 8;
  localparam int AW = 2;

`ifdef RF_SEQ_DUP_READ_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_z, flag_n, flag_v;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  // Register file model: combinational read, write on rf_we, bench preload port when idle
  logic [DW-1:0] rf_mem [4];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign rf_rdata = rf_mem[rf_raddr];

  always @(posedge clk) begin
    if (rf_we)       rf_mem[rf_waddr] <= rf_wdata;
    else if (pre_we) rf_mem[pre_addr] <= pre_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          z, n, v;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares each write-back against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!reset) begin
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("waddr",   32'(rf_waddr), 32'(e.waddr));
          check("wdata",   32'(rf_wdata), 32'(e.wdata));
          check("result",  32'(result),   32'(e.wdata));
          check("flag_z",  32'(flag_z),   32'(e.z));
          check("flag_n",  32'(flag_n),   32'(e.n));
          check("flag_v",  32'(flag_v),   32'(e.v));
          check("latency", 32'(cyc - a),  32'(e.lat));
          check("ready_in_wb", 32'(cmd_ready), 32'd0);
        end
      end
      if (done !== rf_we) check("done_vs_we", 32'(done), 32'(rf_we));
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(cmd_ready && exp_q.size() == 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wait_idle();
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic [DW-1:0] wd,
                       input logic z, input logic n, input logic v, input bit hold_busy);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.waddr = rd; e.wdata = wd; e.z = z; e.n = n; e.v = v;
    e.lat   = (SKIP && ra == rb) ? 3 : 4;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    // Scramble the command fields: the sequencer must ignore them once accepted
    cmd_op = ~op; cmd_rd = ~rd; cmd_ra = ~ra; cmd_rb = ~rb;
    if (hold_busy) begin
      repeat (3) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},  32'(cmd_ready), 32'd1);
    check({tag, "_we"},     32'(rf_we),     32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_raddr"},  32'(rf_raddr),  32'd0);
    check({tag, "_waddr"},  32'(rf_waddr),  32'd0);
    check({tag, "_wdata"},  32'(rf_wdata),  32'd0);
    check({tag, "_result"}, 32'(result),    32'd0);
    check({tag, "_flags"},  32'({flag_z, flag_n, flag_v}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    // ADD R0 = R1 + R2 = 0x05 + 0x03
    preload(2'd1, 8'h05);
    preload(2'd2, 8'h03);
    issue(2'b00, 2'd0, 2'd1, 2'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    // SUB R3 = R2 - R1 = 0x03 - 0x05
    issue(2'b01, 2'd3, 2'd2, 2'd1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    // ADD with rd == ra: old R0 (0x7F) used, signed overflow
    preload(2'd0, 8'h7F);
    preload(2'd1, 8'h01);
    issue(2'b00, 2'd0, 2'd0, 2'd1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    // SUB overflow: 0x80 - 0x01 = 0x7F
    issue(2'b01, 2'd3, 2'd0, 2'd1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    // AND to zero with cmd_valid held through the busy window
    preload(2'd2, 8'h0F);
    preload(2'd3, 8'hF0);
    issue(2'b10, 2'd1, 2'd2, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("held_valid_single_write", 32'(exp_q.size()), 32'd0);
    check("and_dest", 32'(rf_mem[1]), 32'h00);
    // MOV with ra == rb (latency depends on the skip build)
    preload(2'd1, 8'h21);
    issue(2'b11, 2'd2, 2'd1, 2'd1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Reset asserted during EXEC: no write may follow
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 2'd1; cmd_ra = 2'd2; cmd_rb = 2'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    check("abort_no_write", 32'(rf_mem[1]), 32'h21);

    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_r0", 32'(rf_mem[0]), 32'h80);
    check("final_r2", 32'(rf_mem[2]), 32'h21);
    check("final_r3", 32'(rf_mem[3]), 32'hF0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
